// File: rtl/invader_rom_arbiter_if.sv
// Requester/ROM bus for the invader sprite ROM arbiter.
// slave: the arbiter side. master: requesters plus the ROM model.
interface invader_rom_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 12,
  parameter int ID_W   = $clog2(N_REQ)
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]       rom_addr;
  logic [DATA_W-1:0]       rom_rgb;
  logic                    rvalid;
  logic [ID_W-1:0]         rid;
  logic [DATA_W-1:0]       rdata;

  modport master (
    output req, addr, rom_rgb,
    input  gnt, rom_addr, rvalid, rid, rdata
  );

  modport slave (
    input  req, addr, rom_rgb,
    output gnt, rom_addr, rvalid, rid, rdata
  );
endinterface

// File: rtl/invader_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous-read sprite ROM between
// N_REQ pixel requesters. At most one grant per cycle; the ROM pixel is
// returned ROM_LAT clocks later, tagged with the winning requester's ID.
module invader_rom_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 12,
  parameter int ROM_LAT = 1,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input logic                  clk,
  input logic                  rst_n,
  invader_rom_arbiter_if.slave bus
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);
  localparam logic [ID_W:0]   N_WIDE  = (ID_W + 1)'(N_REQ);

  logic [N_REQ-1:0]              req;
  logic [ADDR_W-1:0]             addr_arr [N_REQ];
  logic [ID_W-1:0]               ptr;
  logic [ID_W-1:0]               winner;
  logic [ID_W-1:0]               scan_idx;
  logic [ID_W:0]                 scan_sum;
  logic                          any_gnt;
  logic [N_REQ-1:0]              gnt;
  logic [ADDR_W-1:0]             rom_addr;
  logic [ADDR_W-1:0]             addr_q;
  logic [ROM_LAT-1:0]            tag_vld;
  logic [ROM_LAT-1:0][ID_W-1:0]  tag_id;
  logic                          rvalid;

  assign req = bus.req;

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign addr_arr[k] = bus.addr[k*ADDR_W +: ADDR_W];
  end

  // Search from ptr upward with explicit modulo wrap; first requester wins.
  // Grants are suppressed while reset is held so nothing is launched then.
  always_comb begin
    any_gnt  = 1'b0;
    winner   = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_sum = {1'b0, ptr} + (ID_W + 1)'(i);
      if (scan_sum >= N_WIDE) scan_sum = scan_sum - N_WIDE;
      scan_idx = scan_sum[ID_W-1:0];
      if (!any_gnt && rst_n && req[scan_idx]) begin
        any_gnt = 1'b1;
        winner  = scan_idx;
      end
    end
  end

  // One-hot grant and ROM address mux; the address holds while idle.
  always_comb begin
    gnt = '0;
    if (any_gnt) gnt[winner] = 1'b1;
    rom_addr = any_gnt ? addr_arr[winner] : addr_q;
  end

  // Pointer moves one past the winner so the winner goes to the back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (any_gnt) begin
      ptr <= (winner == LAST_ID) ? '0 : winner + 1'b1;
    end
  end

  // Hold register for the last granted address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else if (any_gnt) begin
      addr_q <= rom_addr;
    end
  end

  // Tag pipeline tracks ROM read latency; reset discards in-flight reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld[0] <= any_gnt;
      tag_id[0]  <= winner;
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  assign rvalid       = tag_vld[ROM_LAT-1];
  assign bus.gnt      = gnt;
  assign bus.rom_addr = rom_addr;
  assign bus.rvalid   = rvalid;
  assign bus.rid      = tag_id[ROM_LAT-1];
  assign bus.rdata    = rvalid ? bus.rom_rgb : '0;

endmodule

// File: doc/invader_rom_arbiter.md
# invader_rom_arbiter

Round-robin arbiter that shares one single-port, synchronous-read invader sprite ROM between several pixel requesters, such as per-row invader draw units and a hit-test unit. It accepts independent request/address pairs, grants at most one per cycle, and drives the ROM address. It returns the ROM pixel tagged with the requester's ID after the ROM's fixed read latency. It sits between the draw/collision logic and a sprite ROM with a 12-bit address `{y[5:0], x[5:0]}` and 12-bit RGB output.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `ADDR_W`, default 12: ROM address width.
- `DATA_W`, default 12: ROM data width (RGB 4:4:4).
- `ROM_LAT`, default 1: ROM read latency in clocks, 1..3.
- `ID_W`, default `$clog2(N_REQ)`: requester ID width.

Ports:
- `clk`, input, 1: system clock. Everything is on its rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `req`, input, `N_REQ`: `req[k]` high means requester k wants a read this cycle.
- `addr`, input, `N_REQ*ADDR_W`: packed addresses; requester k occupies bits `[k*ADDR_W +: ADDR_W]`.
- `gnt`, output, `N_REQ`: one-hot or zero; combinational; `gnt[k]` means requester k's address is taken this cycle.
- `rom_addr`, output, `ADDR_W`: address to the ROM, registered-hold (see Operation).
- `rom_rgb`, input, `DATA_W`: ROM read data, valid `ROM_LAT` clocks after the address edge.
- `rvalid`, output, 1: response valid.
- `rid`, output, `ID_W`: requester index for the current response.
- `rdata`, output, `DATA_W`: response pixel; equals `rom_rgb` while `rvalid` is high.

## Operation
- Arbitration is combinational each cycle over `req`:
  - Search starts at pointer `ptr` and proceeds `ptr`, `ptr+1`, … modulo `N_REQ`.
  - The first set `req` bit wins, and `gnt` is one-hot at that index.
  - If `req == 0`, then `gnt == 0`.
- `ptr` is a register of width `ID_W`. On a granted cycle it becomes `(winner+1) mod N_REQ`. It is unchanged on idle cycles. Reset value is 0.
- ROM address mux:
  - `rom_addr = addr[winner]` when a grant occurs.
  - Otherwise `rom_addr` holds the last granted address, so there is no ROM address toggling while idle.
  - The hold register resets to 0.
- Handshake: a requester keeps `req` and its address stable until it sees `gnt` high in the same cycle. It may then present a new address with `req` high on the next cycle. A requester that drops `req` before being granted is legal and gets no response.
- Tag pipeline: a shift register `ROM_LAT` deep of `{valid, id}`.
  - Stage 0 loads `{|gnt, winner}` each clock.
  - The last stage drives `rvalid` and `rid`.
- `rdata` is `rom_rgb` passed through when `rvalid` is high, and is forced to 0 when `rvalid` is low.
- Throughput: one grant per cycle. A requester asserting `req` continuously while others also request is served once every ≤ `N_REQ` cycles, so there is no starvation.
- Out-of-range `ptr` cannot occur for non-power-of-two `N_REQ`. The wrap is explicit: `ptr == N_REQ-1` wraps to 0.

## Timing
- Reset values while `rst_n` is low:
  - `ptr = 0`, `rom_addr = 0`, all tag stages invalid.
  - Therefore `rvalid = 0`, `rid = 0`, `rdata = 0`, and `gnt = 0` regardless of `req`.
- Reset is asynchronous on assertion. The first grant is possible in the first cycle after `rst_n` is sampled high.
- Reset mid-operation: in-flight responses are discarded, and no `rvalid` is produced for grants issued before reset.
- Latency: grant in cycle t produces `rvalid` in cycle t+`ROM_LAT` (t+1 for the default). Responses come in grant order, one per cycle at most.
- `gnt` depends combinationally on `req` and `ptr` only, with no dependency on `addr`. `rom_addr` is combinational from `addr` on grant cycles, so the ROM samples it at the next edge.
- Simultaneous events:
  - All requesters high with `ptr = 2` gives `gnt` in the order 2, 3, 0, 1, 2, …
  - A requester re-asserting `req` right after being granted waits behind the others.
- Single requester: if only k requests every cycle, it is granted every cycle and `ptr` stays at `k+1`.

## Test plan
- Reset then single requester: `req = 4'b0100`, `addr[2] = 12'h041` → `gnt = 4'b0100` in cycle t, `rom_addr = 12'h041`; `rvalid = 1`, `rid = 2`, `rdata = rom[12'h041]` at t+1.
- All four requesting continuously from reset → grants 0, 1, 2, 3, 0, … one per cycle; response `rid` sequence 0, 1, 2, 3 delayed by one cycle; every `rdata` matches its address's ROM word.
- Idle gap: after a grant of `12'h7FF`, hold `req = 0` for 5 cycles → `gnt = 0`, `rom_addr` stays `12'h7FF`, `rvalid = 0`, `rdata = 0`, `ptr` unchanged.
- Wrap and fairness: `ptr = 3`, `req = 4'b1001` → grant 3 then 0 then 3; no requester waits more than 4 cycles over 1000 random cycles, checked by scoreboard.
- Reset mid-flight: grant in cycle t, pull `rst_n` low asynchronously before edge t+1 → `rvalid` never asserts for that grant; after release, `ptr = 0`.
- `ROM_LAT = 3` build: random requests with a ROM model of latency 3 → each response arrives exactly 3 cycles after its grant with the correct `rid` and `rdata`.
